systolic_scheduler: RTL



---
 rtl/systolic_scheduler_if.sv | 25 ++
 rtl/systolic_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/systolic_scheduler_if.sv
// Job/result handshake bundle for the systolic scheduler.
// Job side: in_valid/in_ready/matrix_A/B; result side: out_valid/out_ready/y.
interface systolic_scheduler_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*N*DW-1:0]      matrix_A;
  logic [N*N*DW-1:0]      matrix_B;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*N*ACC_W-1:0]   y;

  modport slave (
    input  in_valid, matrix_A, matrix_B, out_ready,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, matrix_A, matrix_B, out_ready,
    input  in_ready, out_valid, y
  );
endinterface

// File: rtl/systolic_scheduler.sv
// Sequencer for the NxN systolic MAC array: latch job, skew-feed, drain, capture.
// Ports: clk, reset, bus (job/result handshake), a_feed/b_feed, pe_clear/pe_en, c_in, busy, done_matrix_mult, jobs_done.
module systolic_scheduler #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int ACC_W     = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_scheduler_if.slave  bus,
  output logic [N*DW-1:0]      a_feed,
  output logic [N*DW-1:0]      b_feed,
  output logic                 pe_clear,
  output logic                 pe_en,
  input  logic [N*N*ACC_W-1:0] c_in,
  output logic                 busy,
  output logic                 done_matrix_mult,
  output logic [15:0]          jobs_done
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, RESULT
  } state_e;

  localparam logic [3:0] FEED_LAST  = 4'(3*N-3);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC-1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [N*N*DW-1:0]     a_q, b_q;
  logic [N*DW-1:0]       fa_q, fa_d;
  logic [N*DW-1:0]       fb_q, fb_d;
  logic [N*N*ACC_W-1:0]  y_q;
  logic [15:0]           jobs_q;
  logic                  done_q;
  logic                  load, cap, hs;

  // Row i of A enters row i of the array delayed by i cycles.
  function automatic logic [N*DW-1:0] skew_a(
    input logic [N*N*DW-1:0] m,
    input logic [3:0]        t
  );
    logic [N*DW-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(t) - i;
      if (k >= 0 && k < N)
        r[(N-1-i)*DW +: DW] = m[(N*N-1-(i*N+k))*DW +: DW];
    end
    return r;
  endfunction

  // Column j of B enters column j delayed by j cycles.
  function automatic logic [N*DW-1:0] skew_b(
    input logic [N*N*DW-1:0] m,
    input logic [3:0]        t
  );
    logic [N*DW-1:0] r;
    int k;
    r = '0;
    for (int j = 0; j < N; j++) begin
      k = int'(t) - j;
      if (k >= 0 && k < N)
        r[(N-1-j)*DW +: DW] = m[(N*N-1-(k*N+j))*DW +: DW];
    end
    return r;
  endfunction

  // Feeds are registered, so each cycle loads the
  // operands for the step the next state will show.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fa_d          = '0;
    fb_d          = '0;
    load          = 1'b0;
    cap           = 1'b0;
    hs            = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    pe_clear      = 1'b0;
    pe_en         = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        pe_clear = 1'b1;
        cnt_d    = '0;
        fa_d     = skew_a(a_q, 4'd0);
        fb_d     = skew_b(b_q, 4'd0);
        state_d  = FEED;
      end
      FEED: begin
        pe_en = 1'b1;
        if (cnt_q == FEED_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
          fa_d  = skew_a(a_q, cnt_q + 4'd1);
          fb_d  = skew_b(b_q, cnt_q + 4'd1);
        end
      end
      DRAIN: begin
        pe_en = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cap     = 1'b1;
          cnt_d   = '0;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESULT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      y_q     <= '0;
      jobs_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      done_q  <= hs;
      if (load) begin
        a_q <= bus.matrix_A;
        b_q <= bus.matrix_B;
      end
      if (cap) y_q <= c_in;
      if (hs) jobs_q <= jobs_q + 16'd1;
    end
  end

  assign a_feed           = fa_q;
  assign b_feed           = fb_q;
  assign bus.y            = y_q;
  assign busy             = (state_q != IDLE);
  assign done_matrix_mult = done_q;
  assign jobs_done        = jobs_q;

endmodule
